// File: rtl/pep_batch_former_pkg.sv
// Shared types and constants for the PBS batch former.
// Types are sized for the default configuration; the modules derive their
// own widths from their parameters so non-default builds remain consistent.
package pep_batch_former_pkg;

    localparam int TOTAL_PBS_NB_DEF  = 16;
    localparam int BATCH_PBS_NB_DEF  = 8;
    localparam int BATCH_NB_DEF      = 2;
    localparam int GRAM_NB_DEF       = 4;
    localparam int FLUSH_TIMEOUT_DEF = 64;

    typedef logic [$clog2(TOTAL_PBS_NB_DEF)-1:0]   pid_t;
    typedef logic [$clog2(BATCH_NB_DEF):0]         batch_id_t;
    typedef logic [$clog2(BATCH_PBS_NB_DEF+1)-1:0] pbs_cnt_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Bit positions inside the sticky err vector.
    localparam int ERR_BDONE = 0;
    localparam int ERR_FREE  = 1;

    // Configuration legality: pool and batch both tile evenly over the GRAMs,
    // a batch fits in the pool, and the timeout is at least one cycle.
    function automatic bit cfg_ok(input int total_pbs_nb, input int batch_pbs_nb,
                                  input int gram_nb, input int flush_timeout);
        return (gram_nb > 0) &&
               (total_pbs_nb % gram_nb == 0) &&
               (batch_pbs_nb % gram_nb == 0) &&
               (total_pbs_nb >= batch_pbs_nb) &&
               (flush_timeout >= 1);
    endfunction

endpackage

// File: rtl/pep_slot_pool.sv
// PBS slot pool: allocation bitmap, lowest-free priority encoder and a
// registered free-slot counter. A grant always takes the lowest free slot as
// seen in registered state, so a slot released in the same cycle can never be
// the one granted.
module pep_slot_pool #(
    parameter int TOTAL_PBS_NB = 16,
    parameter int PID_W        = $clog2(TOTAL_PBS_NB)
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             grant,
    input  logic             rel_vld,
    input  logic [PID_W-1:0] rel_pid,
    output logic [PID_W-1:0] free_pid,
    output logic [PID_W:0]   free_cnt,
    output logic             rel_err
);

    logic [TOTAL_PBS_NB-1:0] alloc;
    logic                    rel_in_range;
    logic                    rel_ok;

    // Lowest-index free slot; scanning downward lets the last hit win.
    always_comb begin
        free_pid = '0;
        for (int i = TOTAL_PBS_NB - 1; i >= 0; i--) begin
            if (!alloc[i]) begin
                free_pid = PID_W'(i);
            end
        end
    end

    assign rel_in_range = (int'(rel_pid) < TOTAL_PBS_NB);
    assign rel_ok       = rel_vld & rel_in_range & alloc[rel_pid];
    assign rel_err      = rel_vld & ~rel_ok;

    // Bitmap and free counter move together; a bad release changes nothing.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            alloc    <= '0;
            free_cnt <= (PID_W+1)'(TOTAL_PBS_NB);
        end else begin
            if (grant) begin
                alloc[free_pid] <= 1'b1;
            end
            if (rel_ok) begin
                alloc[rel_pid] <= 1'b0;
            end
            free_cnt <= free_cnt + (PID_W+1)'(rel_ok) - (PID_W+1)'(grant);
        end
    end

endmodule

// File: rtl/pep_batch_former.sv
// PBS batch former: hands out slot ids, collects them into a pending batch,
// closes the batch on full / idle timeout / flush, and presents it to the
// batch pipe while bounding the number of batches in flight.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FILL  | accepting slot requests into the pending batch
// ST_ISSUE | closed batch held on bcmd_* until the pipe takes it
module pep_batch_former
    import pep_batch_former_pkg::*;
#(
    parameter int TOTAL_PBS_NB  = TOTAL_PBS_NB_DEF,
    parameter int BATCH_PBS_NB  = BATCH_PBS_NB_DEF,
    parameter int BATCH_NB      = BATCH_NB_DEF,
    parameter int GRAM_NB       = GRAM_NB_DEF,
    parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
    parameter int PID_W         = $clog2(TOTAL_PBS_NB)
) (
    input  logic                              clk,
    input  logic                              a_rst,
    input  logic                              req_vld,
    output logic                              req_rdy,
    output logic [PID_W-1:0]                  req_pid,
    input  logic                              flush,
    output logic                              bcmd_vld,
    input  logic                              bcmd_rdy,
    output logic [TOTAL_PBS_NB-1:0]           bcmd_mask,
    output logic [$clog2(BATCH_PBS_NB+1)-1:0] bcmd_pbs_nb,
    output logic [$clog2(BATCH_NB):0]         bcmd_id,
    input  logic                              bdone_vld,
    input  logic                              pid_free_vld,
    input  logic [PID_W-1:0]                  pid_free,
    output logic [PID_W:0]                    free_cnt,
    output logic [$clog2(BATCH_NB+1)-1:0]     inflight_cnt,
    output logic [1:0]                        err
);

    localparam int CNT_W = $clog2(BATCH_PBS_NB + 1);
    localparam int ID_W  = $clog2(BATCH_NB) + 1;
    localparam int INF_W = $clog2(BATCH_NB + 1);
    localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);

    if (!cfg_ok(TOTAL_PBS_NB, BATCH_PBS_NB, GRAM_NB, FLUSH_TIMEOUT)) begin : g_cfg_err
        $error("pep_batch_former: illegal slot/batch/GRAM/timeout configuration");
    end

    state_t                  state;
    logic [TOTAL_PBS_NB-1:0] pend_mask;
    logic [CNT_W-1:0]        pend_cnt;
    logic [TMR_W-1:0]        timer;

    logic                    grant;
    logic [TOTAL_PBS_NB-1:0] grant_oh;
    logic                    pend_any;
    logic                    close;
    logic                    handshake;
    logic                    bdone_ok;
    logic                    bdone_err;
    logic                    free_err;

    pep_slot_pool #(
        .TOTAL_PBS_NB (TOTAL_PBS_NB),
        .PID_W        (PID_W)
    ) u_slot_pool (
        .clk      (clk),
        .a_rst    (a_rst),
        .grant    (grant),
        .rel_vld  (pid_free_vld),
        .rel_pid  (pid_free),
        .free_pid (req_pid),
        .free_cnt (free_cnt),
        .rel_err  (free_err)
    );

    assign req_rdy   = (state == ST_FILL) && (free_cnt != '0) &&
                       (pend_cnt < CNT_W'(BATCH_PBS_NB));
    assign grant     = req_vld & req_rdy;
    assign grant_oh  = TOTAL_PBS_NB'(1) << req_pid;
    assign pend_any  = (pend_cnt != '0);

    // A grant landing in the closing cycle rides along in the closed batch.
    assign close     = (state == ST_FILL) &&
                       ((pend_cnt == CNT_W'(BATCH_PBS_NB)) ||
                        (pend_any && (timer == TMR_W'(FLUSH_TIMEOUT - 1))) ||
                        (pend_any && flush));

    assign handshake = (state == ST_ISSUE) && bcmd_rdy &&
                       (inflight_cnt < INF_W'(BATCH_NB));
    assign bdone_ok  = bdone_vld && (inflight_cnt != '0);
    assign bdone_err = bdone_vld && (inflight_cnt == '0);

    // Batch FSM with its pending set, idle timer and registered command outputs.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state       <= ST_FILL;
            pend_mask   <= '0;
            pend_cnt    <= '0;
            timer       <= '0;
            bcmd_vld    <= 1'b0;
            bcmd_mask   <= '0;
            bcmd_pbs_nb <= '0;
            bcmd_id     <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (close) begin
                        state       <= ST_ISSUE;
                        bcmd_vld    <= 1'b1;
                        bcmd_mask   <= pend_mask | (grant ? grant_oh : '0);
                        bcmd_pbs_nb <= pend_cnt + CNT_W'(grant);
                        pend_mask   <= '0;
                        pend_cnt    <= '0;
                        timer       <= '0;
                    end else if (grant) begin
                        pend_mask <= pend_mask | grant_oh;
                        pend_cnt  <= pend_cnt + CNT_W'(1);
                        timer     <= '0;
                    end else if (!pend_any) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (handshake) begin
                        state    <= ST_FILL;
                        bcmd_vld <= 1'b0;
                        if (bcmd_id == ID_W'(2 * BATCH_NB - 1)) begin
                            bcmd_id <= '0;
                        end else begin
                            bcmd_id <= bcmd_id + ID_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    bcmd_vld <= 1'b0;
                end
            endcase
        end
    end

    // In-flight batch count; issue and completion in one cycle cancel out.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            inflight_cnt <= '0;
        end else begin
            inflight_cnt <= inflight_cnt + INF_W'(handshake) - INF_W'(bdone_ok);
        end
    end

    // Sticky protocol error flags.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            err <= '0;
        end else begin
            if (bdone_err) begin
                err[ERR_BDONE] <= 1'b1;
            end
            if (free_err) begin
                err[ERR_FREE] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pep_batch_former.sv
// Directed bench for pep_batch_former in its default configuration
// (16 slots, 8 per batch, 2 in flight, 64-cycle idle timeout).
module tb_pep_batch_former;

    localparam int TOTAL_PBS_NB  = 16;
    localparam int BATCH_PBS_NB  = 8;
    localparam int BATCH_NB      = 2;
    localparam int GRAM_NB       = 4;
    localparam int FLUSH_TIMEOUT = 64;
    localparam int PID_W         = 4;

    logic                    clk = 1'b0;
    logic                    a_rst;
    logic                    req_vld;
    logic                    req_rdy;
    logic [PID_W-1:0]        req_pid;
    logic                    flush;
    logic                    bcmd_vld;
    logic                    bcmd_rdy;
    logic [TOTAL_PBS_NB-1:0] bcmd_mask;
    logic [3:0]              bcmd_pbs_nb;
    logic [1:0]              bcmd_id;
    logic                    bdone_vld;
    logic                    pid_free_vld;
    logic [PID_W-1:0]        pid_free;
    logic [PID_W:0]          free_cnt;
    logic [1:0]              inflight_cnt;
    logic [1:0]              err;

    int checks = 0;
    int errors = 0;

    pep_batch_former #(
        .TOTAL_PBS_NB  (TOTAL_PBS_NB),
        .BATCH_PBS_NB  (BATCH_PBS_NB),
        .BATCH_NB      (BATCH_NB),
        .GRAM_NB       (GRAM_NB),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_pid      (req_pid),
        .flush        (flush),
        .bcmd_vld     (bcmd_vld),
        .bcmd_rdy     (bcmd_rdy),
        .bcmd_mask    (bcmd_mask),
        .bcmd_pbs_nb  (bcmd_pbs_nb),
        .bcmd_id      (bcmd_id),
        .bdone_vld    (bdone_vld),
        .pid_free_vld (pid_free_vld),
        .pid_free     (pid_free),
        .free_cnt     (free_cnt),
        .inflight_cnt (inflight_cnt),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic free_slot(input int pid);
        pid_free_vld = 1'b1;
        pid_free     = PID_W'(pid);
        tick();
        pid_free_vld = 1'b0;
    endtask

    initial begin
        int n;
        a_rst        = 1'b1;
        req_vld      = 1'b0;
        flush        = 1'b0;
        bcmd_rdy     = 1'b0;
        bdone_vld    = 1'b0;
        pid_free_vld = 1'b0;
        pid_free     = '0;
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b0;

        // Reset state
        check_val("rst_free_cnt", 32'(free_cnt), 16);
        check_val("rst_bcmd_vld", 32'(bcmd_vld), 0);
        check_val("rst_bcmd_mask", 32'(bcmd_mask), 0);
        check_val("rst_inflight", 32'(inflight_cnt), 0);
        check_val("rst_err", 32'(err), 0);
        tick();
        check_val("rst_req_rdy", 32'(req_rdy), 1);
        check_val("rst_req_pid", 32'(req_pid), 0);

        // Three grants then idle: close by timeout 64 cycles after last grant
        req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("to_req_pid", 32'(req_pid), 32'(i));
            tick();
        end
        req_vld = 1'b0;
        n = 0;
        while (!bcmd_vld && n < 200) begin
            tick();
            n++;
        end
        check_val("to_close_delay", 32'(n), 64);
        check_val("to_mask", 32'(bcmd_mask), 'h0007);
        check_val("to_pbs_nb", 32'(bcmd_pbs_nb), 3);
        check_val("to_id", 32'(bcmd_id), 0);
        check_val("to_issue_stall", 32'(req_rdy), 0);
        bcmd_rdy = 1'b1;
        tick();
        check_val("to_hs_vld", 32'(bcmd_vld), 0);
        check_val("to_hs_inflight", 32'(inflight_cnt), 1);
        check_val("to_hs_id", 32'(bcmd_id), 1);
        bdone_vld = 1'b1;
        tick();
        bdone_vld = 1'b0;
        check_val("bdone_inflight", 32'(inflight_cnt), 0);

        // Flush with nothing pending is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        check_val("empty_flush_vld", 32'(bcmd_vld), 0);
        check_val("empty_flush_rdy", 32'(req_rdy), 1);
        for (int i = 0; i < 3; i++) free_slot(i);
        check_val("refill_free_cnt", 32'(free_cnt), 16);
        check_val("refill_err", 32'(err), 0);

        // Eight back-to-back grants close a full batch
        req_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val("full_req_rdy", 32'(req_rdy), 1);
            check_val("full_req_pid", 32'(req_pid), 32'(i));
            tick();
        end
        req_vld = 1'b0;
        check_val("full_pre_vld", 32'(bcmd_vld), 0);
        check_val("full_pre_rdy", 32'(req_rdy), 0);
        tick();
        check_val("full_vld", 32'(bcmd_vld), 1);
        check_val("full_mask", 32'(bcmd_mask), 'h00FF);
        check_val("full_pbs_nb", 32'(bcmd_pbs_nb), 8);
        check_val("full_id", 32'(bcmd_id), 1);
        tick();
        check_val("full_hs_inflight", 32'(inflight_cnt), 1);

        // Second full batch drains the pool
        req_vld = 1'b1;
        for (int i = 8; i < 16; i++) begin
            check_val("full2_req_pid", 32'(req_pid), 32'(i));
            tick();
        end
        req_vld = 1'b0;
        check_val("pool_empty_cnt", 32'(free_cnt), 0);
        check_val("pool_empty_rdy", 32'(req_rdy), 0);
        tick();
        check_val("full2_mask", 32'(bcmd_mask), 'hFF00);
        check_val("full2_id", 32'(bcmd_id), 2);
        tick();
        check_val("full2_inflight", 32'(inflight_cnt), 2);
        check_val("full2_vld", 32'(bcmd_vld), 0);
        check_val("pool_empty_rdy2", 32'(req_rdy), 0);

        // Release pid 5: grantable next cycle
        free_slot(5);
        check_val("rel5_rdy", 32'(req_rdy), 1);
        check_val("rel5_pid", 32'(req_pid), 5);
        check_val("rel5_cnt", 32'(free_cnt), 1);
        free_slot(6);
        free_slot(7);
        check_val("rel67_cnt", 32'(free_cnt), 3);

        // Grant 5, then grant 6 together with flush: both in the batch
        req_vld = 1'b1;
        tick();
        check_val("fl_req_pid", 32'(req_pid), 6);
        flush = 1'b1;
        tick();
        req_vld = 1'b0;
        flush   = 1'b0;
        check_val("fl_vld", 32'(bcmd_vld), 1);
        check_val("fl_mask", 32'(bcmd_mask), 'h0060);
        check_val("fl_pbs_nb", 32'(bcmd_pbs_nb), 2);
        check_val("fl_id", 32'(bcmd_id), 3);

        // Pipe full: batch held until a bdone frees a place
        tick();
        tick();
        check_val("pipefull_vld", 32'(bcmd_vld), 1);
        check_val("pipefull_inflight", 32'(inflight_cnt), 2);
        check_val("pipefull_rdy", 32'(req_rdy), 0);
        bdone_vld = 1'b1;
        tick();
        bdone_vld = 1'b0;
        check_val("pipefull_bdone_vld", 32'(bcmd_vld), 1);
        check_val("pipefull_bdone_inf", 32'(inflight_cnt), 1);
        tick();
        check_val("pipefull_hs_vld", 32'(bcmd_vld), 0);
        check_val("pipefull_hs_inf", 32'(inflight_cnt), 2);
        check_val("id_wrap", 32'(bcmd_id), 0);
        check_val("after_fl_free_cnt", 32'(free_cnt), 1);

        // Free and grant in the same cycle
        check_val("same_req_pid", 32'(req_pid), 7);
        req_vld      = 1'b1;
        pid_free_vld = 1'b1;
        pid_free     = PID_W'(0);
        tick();
        req_vld      = 1'b0;
        pid_free_vld = 1'b0;
        check_val("same_free_cnt", 32'(free_cnt), 1);
        check_val("same_req_pid_next", 32'(req_pid), 0);

        // Error flags
        free_slot(0);
        check_val("err_free", 32'(err), 2);
        check_val("err_free_cnt", 32'(free_cnt), 1);
        bdone_vld = 1'b1;
        tick();
        tick();
        check_val("err_drain_inf", 32'(inflight_cnt), 0);
        check_val("err_drain_err", 32'(err), 2);
        tick();
        bdone_vld = 1'b0;
        check_val("err_bdone", 32'(err), 3);
        check_val("err_bdone_inf", 32'(inflight_cnt), 0);

        // Asynchronous reset while holding a batch in ISSUE
        bcmd_rdy = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        check_val("pre_rst_vld", 32'(bcmd_vld), 1);
        check_val("pre_rst_mask", 32'(bcmd_mask), 'h0080);
        #2;
        a_rst = 1'b1;
        #1;
        check_val("arst_vld", 32'(bcmd_vld), 0);
        check_val("arst_free_cnt", 32'(free_cnt), 16);
        check_val("arst_err", 32'(err), 0);
        check_val("arst_mask", 32'(bcmd_mask), 0);
        check_val("arst_pbs_nb", 32'(bcmd_pbs_nb), 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        tick();
        check_val("post_rst_rdy", 32'(req_rdy), 1);
        check_val("post_rst_pid", 32'(req_pid), 0);
        req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        check_val("post_rst_next_pid", 32'(req_pid), 1);
        check_val("post_rst_free_cnt", 32'(free_cnt), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
